// File: rtl/ula_cmp_flag_gen.sv
// ula_cmp_flag_gen: bit-serial (b - a) comparator producing zero/sign flags.
// Optional macro ULA_CMP_UNSIGNED_EN adds unsigned_mode (zero-extended operands).
module ula_cmp_flag_gen #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef ULA_CMP_UNSIGNED_EN
    input  logic               unsigned_mode,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               zero_flag,
    output logic               sign_flag,
    output logic [2*WIDTH-1:0] result
);

    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     b_q, b_d;
    logic [WIDTH:0]     diff_q, diff_d;
    logic               carry_q, carry_d;
    logic               zacc_q, zacc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic ext_a;
    logic ext_b;
    logic accept;
    logic last;
    logic na_bit;
    logic diff_bit;

    always_comb begin
        ext_a = a[WIDTH-1];
        ext_b = b[WIDTH-1];
`ifdef ULA_CMP_UNSIGNED_EN
        if (unsigned_mode) begin
            ext_a = 1'b0;
            ext_b = 1'b0;
        end
`endif
        accept   = start && ((state_q == IDLE) || (state_q == DONE));
        na_bit   = ~a_q[0];
        diff_bit = b_q[0] ^ na_bit ^ carry_q;
        last     = (idx_q == IW'(WIDTH));

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        idx_d    = idx_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        result_d = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Bit WIDTH carries the extension so the serial loop
                    // just keeps consuming bit 0.
                    a_d     = {ext_a, a};
                    b_d     = {ext_b, b};
                    diff_d  = '0;
                    carry_d = 1'b1;
                    zacc_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = (b_q[0] & na_bit) | (b_q[0] & carry_q) |
                          (na_bit & carry_q);
                diff_d  = {diff_bit, diff_q[WIDTH:1]};
                zacc_d  = zacc_q | diff_bit;
                idx_d   = idx_q + IW'(1);
                if (last) begin
                    zero_d   = ~(zacc_q | diff_bit);
                    sign_d   = diff_bit;
                    result_d = {{(WIDTH-1){diff_bit}}, diff_bit,
                                diff_q[WIDTH:1]};
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign zero_flag = zero_q;
    assign sign_flag = sign_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ula_cmp_flag_gen.sv
// tb_ula_cmp_flag_gen: scoreboard bench for the bit-serial compare flag unit.
// Expected results come from a plain arithmetic model of (b - a).
module tb_ula_cmp_flag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        um_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        busy;
    logic        done;
    logic        zero_flag;
    logic        sign_flag;
    logic [15:0] result;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        s;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    bit   mon_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    ula_cmp_flag_gen #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef ULA_CMP_UNSIGNED_EN
        .unsigned_mode(um_i),
`endif
        .a            (a_i),
        .b            (b_i),
        .busy         (busy),
        .done         (done),
        .zero_flag    (zero_flag),
        .sign_flag    (sign_flag),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic um);
        logic [8:0] ae;
        logic [8:0] be;
        logic [8:0] d;
        exp_t       e;
        ae    = {(um ? 1'b0 : av[7]), av};
        be    = {(um ? 1'b0 : bv[7]), bv};
        d     = be - ae;
        e.res = {{7{d[8]}}, d};
        e.z   = (d == 9'd0);
        e.s   = d[8];
        return e;
    endfunction

    // Scoreboard monitor: pop on done, otherwise outputs must hold.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("unexp_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result", result, e.res);
                    check_eq("zero", zero_flag, e.z);
                    check_eq("sign", sign_flag, e.s);
                    check_eq("busy_at_done", busy, 0);
                    hold = e;
                end
            end else begin
                check_eq("hold_res", result, hold.res);
                check_eq("hold_zero", zero_flag, hold.z);
                check_eq("hold_sign", sign_flag, hold.s);
            end
        end
    end

    task automatic drive_start(input logic [7:0] av, input logic [7:0] bv,
                               input logic um);
        a_i   = av;
        b_i   = bv;
        um_i  = um;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(model(av, bv, um));
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
            edges++;
            if (edges > 40) begin
                check_eq("timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic um);
        int e;
        int bn;
        drive_start(av, bv, um);
        wait_done(e, bn);
        check_eq("latency", e, 9);
        check_eq("busy_len", bn, 9);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int bn;
        rst   = 1'b1;
        start = 1'b0;
        um_i  = 1'b0;
        a_i   = '0;
        b_i   = '0;
        hold  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_zero", zero_flag, 0);
        check_eq("rst_sign", sign_flag, 0);
        check_eq("rst_result", result, 0);
        @(posedge clk);
        #1;

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h03, 1'b0);
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);

        // Back-to-back: start held high through RUN and DONE.
        a_i   = 8'h7F;
        b_i   = 8'h80;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(model(8'h7F, 8'h80, 1'b0));
        #1 a_i = 8'h22;
        b_i = 8'h11;
        wait_done(e, bn);
        check_eq("b2b_lat1", e, 9);
        @(posedge clk);
        sb.push_back(model(8'h22, 8'h11, 1'b0));
        #1 start = 1'b0;
        wait_done(e, bn);
        check_eq("b2b_lat2", e, 9);
        check_eq("b2b_busy2", bn, 9);
        @(posedge clk);
        #1;

        // Mid-RUN start pulse and operand change are ignored.
        drive_start(8'h10, 8'h20, 1'b0);
        repeat (3) @(posedge clk);
        #1 a_i = 8'hFF;
        b_i   = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(e, bn);
        check_eq("midrun_lat", e, 5);
        @(posedge clk);
        #1;

        // Reset during RUN cycle 4 aborts the op.
        drive_start(8'h05, 8'h03, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        sb.delete();
        hold = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_zero", zero_flag, 0);
        check_eq("abort_sign", sign_flag, 0);
        check_eq("abort_result", result, 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        run_op(8'h05, 8'h03, 1'b0);

        // Reset and start together: reset wins.
        a_i   = 8'h01;
        b_i   = 8'h02;
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        sb.delete();
        hold = '0;
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_busy", busy, 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;

`ifdef ULA_CMP_UNSIGNED_EN
        run_op(8'h80, 8'h7F, 1'b1);
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'h01, 8'hFF, 1'b1);
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'b0);
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_cmp_flag_gen.md
Name: ula_cmp_flag_gen

Overview:
- Sequential flag producer for the ULA comparison block; generates zero_flag and sign_flag for the eq/gte/lte outputs.
- Computes the true (WIDTH+1)-bit difference b - a bit-serially, LSB first, one bit per clock.
- Also publishes the sign-extended difference on a 16-bit ULA-style result bus.
- Flag convention matches the consumers:
  - sign_flag = 1 means a > b, because (b - a) is negative.
  - gte = zero | sign.
  - lte = zero | ~sign.

Parameters:
- WIDTH, 8, operand width in bits. The result bus is 2*WIDTH bits wide.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- a  input  WIDTH  operand a; captured on an accepted start.
- b  input  WIDTH  operand b; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when the flags and result become valid.
- zero_flag  output  1  (b - a) == 0.
- sign_flag  output  1  true sign of (b - a), i.e. a > b.
- result  output  2*WIDTH  (b - a) sign-extended from WIDTH+1 bits.

Behaviour:
- One clock domain. Reset is synchronous and active-high, taking effect at the clk edge where rst = 1.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0.
  - zero_flag = 0, sign_flag = 0.
  - result = 0.
  - Internal operand, borrow and index registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 latches a and b into shift registers, sets carry = 1 (b + ~a + 1), sets index = 0 and the zero accumulator = 0, then goes to RUN.
  - start = 0: stay in IDLE.
- RUN:
  - Each cycle computes diff bit i = b_i ^ ~a_i ^ carry and updates carry.
  - The diff bit is shifted into a WIDTH+1 diff register; the zero accumulator ORs in the diff bit.
  - For i = WIDTH, operands are sign-extended: a_WIDTH = a[WIDTH-1], b_WIDTH = b[WIDTH-1].
  - After processing i = WIDTH (WIDTH+1 RUN cycles), the same edge:
    - registers zero_flag = ~(accumulator | last bit);
    - registers sign_flag = last bit;
    - registers result = the diff register, sign-extended to 2*WIDTH;
    - goes to DONE.
- DONE (one cycle):
  - done = 1.
  - start = 1 is accepted exactly as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
- Latency: start sampled at edge E0; RUN spans WIDTH+1 cycles; done is high in the cycle after edge E(WIDTH+1), i.e. 9 cycles after the start edge at WIDTH = 8.
- Flag and result hold:
  - zero_flag, sign_flag and result hold their last values until the next completion; they do not change during RUN.
  - They are cleared only by rst.
- Boundary conditions:
  - start during RUN is ignored; operands are not re-captured.
  - a and b changing during RUN have no effect.
  - rst in any state, including mid-RUN, aborts: IDLE with all outputs at reset values, and no done pulse.
  - rst and start in the same cycle: rst wins.
  - Extremes need no overflow flag, because the WIDTH+1 difference spans -(2^WIDTH - 1) .. 2^WIDTH - 1.

Optional Feature:
- Macro: ULA_CMP_UNSIGNED_EN.
- Defined:
  - Adds port unsigned_mode, input, 1 bit, captured with the operands on start.
  - When the captured value is 1, bit WIDTH of both operands is 0 (zero-extension), so flags and result reflect the unsigned compare.
- Undefined:
  - No port; operation is always signed as described above.

Test Plan:
- a = 0x05, b = 0x03, start pulse -> done 9 cycles later; result = 0xFFFE, zero = 0, sign = 1; busy high for exactly 9 cycles.
- a = 0x03, b = 0x03 -> result = 0x0000, zero = 1, sign = 0. Then a = 0x80, b = 0x7F -> result = 0x00FF, sign = 0.
- a = 0x7F, b = 0x80 -> result = 0xFF01, sign = 1. Start held high through DONE gives back-to-back ops with no idle cycle; a start pulse mid-RUN is ignored.
- Operands changed mid-RUN (a = 0x10, b = 0x20 captured, then driven 0xFF/0x00) -> result = 0x0010, sign = 0.
- Reset asserted at RUN cycle 4 -> next cycle busy = 0, flags = 0, result = 0, no done. A subsequent start completes normally.
- With ULA_CMP_UNSIGNED_EN and unsigned_mode = 1: a = 0x80, b = 0x7F -> result = 0xFFFF, sign = 1. With unsigned_mode = 0 the same operands -> 0x00FF, sign = 0.
